// File: rtl/hazard_control_pkg.sv
// Shared core types for the hazard controller.
// Optional PERF_CNT_EN build adds stall/flush counters.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int REG_W_DEF = 5;
  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/hazard_control_if.sv
// Pipeline <-> hazard controller bundle.
// PERF_CNT_EN gives the counter fields real values.
interface hazard_control_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rm;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             pc_sel_branch;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rn, id_rm, id_uses_rm,
    output ex_rd, ex_mem_read,
    output br_taken, mem_req, mem_ready,
    input  pc_write, ifid_write,
    input  idex_write, exmem_write,
    input  idex_bubble, ifid_flush,
    input  pc_sel_branch,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rm,
    input  ex_rd, ex_mem_read,
    input  br_taken, mem_req, mem_ready,
    output pc_write, ifid_write,
    output idex_write, exmem_write,
    output idex_bubble, ifid_flush,
    output pc_sel_branch,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter with async active-low clear.
// Instantiated by hazard_control only under PERF_CNT_EN.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_control.sv
// Load-use / branch-flush / memory-wait stall controller.
// Define PERF_CNT_EN to build the stall/flush counters.
module hazard_control
  import cpu_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 32
) (
  input logic             clk,
  input logic             reset_n,
  hazard_control_if.slave hz
);

  hz_state_e  state_q, state_d;
  hz_state_e  ret_q, ret_d;
  hz_state_e  cur;
  logic [1:0] left_q, left_d;
  logic       mem_wait;
  logic       rn_hit;
  logic       rm_hit;
  logic       load_use;

  assign mem_wait = hz.mem_req && !hz.mem_ready;

  // Leaving MEM_WAIT behaves as the interrupted state.
  assign cur = (state_q == MEM_WAIT) ? ret_q : state_q;

  assign rn_hit = hz.ex_rd == hz.id_rn;
  assign rm_hit = hz.id_uses_rm
               && (hz.ex_rd == hz.id_rm);
  assign load_use = hz.ex_mem_read
                 && (hz.ex_rd != REG_W'(XZR_IDX))
                 && (rn_hit || rm_hit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    left_d  = left_q;
    if (mem_wait) begin
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT)
        ret_d = state_q;
    end else if (hz.br_taken) begin
      if (BR_PENALTY > 1) begin
        state_d = BR_FLUSH;
        left_d  = 2'(BR_PENALTY - 1);
      end else begin
        state_d = RUN;
        left_d  = '0;
      end
    end else if (cur == BR_FLUSH) begin
      left_d  = left_q - 2'd1;
      state_d = (left_q == 2'd1) ? RUN
                                 : BR_FLUSH;
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    hz.pc_write      = 1'b1;
    hz.ifid_write    = 1'b1;
    hz.idex_write    = 1'b1;
    hz.exmem_write   = 1'b1;
    hz.idex_bubble   = 1'b0;
    hz.ifid_flush    = 1'b0;
    hz.pc_sel_branch = 1'b0;
    if (!reset_n) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_write  = 1'b0;
      hz.exmem_write = 1'b0;
      hz.idex_bubble = 1'b1;
      hz.ifid_flush  = 1'b1;
    end else if (mem_wait) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_write  = 1'b0;
      hz.exmem_write = 1'b0;
    end else if (hz.br_taken) begin
      hz.pc_sel_branch = 1'b1;
      hz.ifid_flush    = 1'b1;
      hz.idex_bubble   = 1'b1;
    end else if (cur == BR_FLUSH) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (load_use) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (!hz.pc_write),
    .count (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (hz.ifid_flush),
    .count (hz.flush_cnt)
  );
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline hazard/stall controller for the 5-stage core. It sits beside the EX-stage operand forwarding logic and drives the pipeline-register enables and flushes around it.
- It handles the cases forwarding cannot cover:
  - load-use (one-cycle bubble);
  - taken-branch redirect (multi-cycle flush);
  - data-memory wait (whole-pipeline freeze).
- Register 31 (XZR) never creates a hazard.

Parameters:
- REG_W, 5, register index width.
- BR_PENALTY, 2, number of cycles (1..3) for which IF/ID and ID/EX are flushed after a taken branch.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rn  in  REG_W  source register A of the instruction in ID.
- id_rm  in  REG_W  source register B of the instruction in ID.
- id_uses_rm  in  1  ID instruction actually reads id_rm.
- ex_rd  in  REG_W  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load (LDUR).
- br_taken  in  1  branch resolved taken in MEM (one-cycle pulse from EX/MEM).
- mem_req  in  1  MEM-stage access in progress.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- idex_write  out  1  ID/EX register enable.
- exmem_write  out  1  EX/MEM and MEM/WB register enable.
- idex_bubble  out  1  load zeros (NOP, all WE=0) into ID/EX.
- ifid_flush  out  1  clear IF/ID to NOP.
- pc_sel_branch  out  1  select the branch target for the PC.
- stall_cnt  out  CNT_W  load-use plus memory-wait stall cycles (only with PERF_CNT_EN).
- flush_cnt  out  CNT_W  branch flush cycles (only with PERF_CNT_EN).

Behaviour:
- FSM states are RUN, BR_FLUSH and MEM_WAIT. It uses a 2-bit down-counter `flush_left`.
- Outputs are combinational from the state and the current inputs. Only the state, `flush_left` and the counters are registered.
- Reset (reset_n=0, asynchronous):
  - state=RUN, flush_left=0, counters=0.
  - While reset is held: pc_write, ifid_write, idex_write and exmem_write are 0; ifid_flush=1, idex_bubble=1, pc_sel_branch=0.
- Default in RUN with no event: all enables 1; ifid_flush=0, idex_bubble=0, pc_sel_branch=0.
- Event priority: memory wait > branch > load-use.
- Memory wait: mem_req=1 and mem_ready=0, in any state.
  - All four enables 0; no flush and no bubble.
  - Next state is MEM_WAIT. The FSM records the interrupted state: RUN or BR_FLUSH, with `flush_left` held.
- MEM_WAIT:
  - Stays frozen while mem_ready=0.
  - On the mem_ready=1 cycle, the enables return to 1 and the FSM returns to the recorded state.
  - br_taken is held stable by the frozen EX/MEM register and is acted on that same cycle.
- Branch: br_taken=1 and not frozen.
  - pc_sel_branch=1, ifid_flush=1, idex_bubble=1, all enables 1.
  - If BR_PENALTY>1: flush_left=BR_PENALTY-1 and next state is BR_FLUSH; otherwise next state is RUN.
- BR_FLUSH:
  - ifid_flush=1 and idex_bubble=1 each cycle; flush_left decrements.
  - Returns to RUN when flush_left reaches 0 (flush_left==1 is the last flush cycle).
  - Load-use detection is suppressed, because the ID instruction is being discarded.
  - A new br_taken in BR_FLUSH reloads flush_left.
- Load-use: only in RUN with no higher-priority event.
  - Condition: ex_mem_read=1, ex_rd!=31, and (ex_rd==id_rn or (id_uses_rm and ex_rd==id_rm)).
  - Response: pc_write=0, ifid_write=0, idex_bubble=1; idex_write=1 and exmem_write=1.
  - Exactly one cycle, with no state change. The next cycle the load is in MEM and forwarding covers it.
- Reset asserted mid-stall, mid-flush or mid-wait: immediate return to RUN with the reset outputs above.

Optional Feature:
- Macro: PERF_CNT_EN.
- With the macro defined:
  - stall_cnt increments on every cycle with pc_write=0 while reset_n=1.
  - flush_cnt increments on every cycle with ifid_flush=1 while reset_n=1.
  - Both counters saturate at all-ones and clear on reset.
- Without the macro: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- The shared package `cpu_pkg` holds:
  - the `hz_state_e` enum (RUN, BR_FLUSH, MEM_WAIT);
  - XZR_IDX = 5'd31;
  - the REG_W default.
- One sub-module, `sat_counter` (width parameter, increment, async active-low clear), is instantiated twice under PERF_CNT_EN.

Test Plan:
- Load-use on rn: ex_mem_read=1, ex_rd=3, id_rn=3 → one cycle of pc_write=0, ifid_write=0, idex_bubble=1; the next cycle is back to all-1 enables.
- XZR and unused rm:
  - ex_rd=31, id_rn=31 → no stall.
  - ex_rd=5, id_rm=5, id_uses_rm=0 → no stall.
- Branch with BR_PENALTY=2: br_taken pulse → pc_sel_branch=1 for 1 cycle, and ifid_flush=1 plus idex_bubble=1 for 2 cycles; a load-use hazard injected in the 2nd cycle is ignored.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → all enables 0 for 3 cycles and 1 on the 4th. A simultaneous br_taken yields pc_sel_branch=1 only on the 4th cycle.
- Reset mid-flush: reset_n dropped asynchronously during BR_FLUSH → outputs reach reset values before the next edge; after release the FSM is in RUN with no residual flush.
- PERF_CNT_EN: 1 load-use stall, a 3-cycle memory wait and 1 branch with BR_PENALTY=2 → stall_cnt=4, flush_cnt=2.
